// File: rtl/imem_port_arbiter_pkg.sv
// Shared types and defaults for the instruction-memory port arbiter.
// Holds the FSM state encoding and the starvation-counter width helper.
package imem_port_arbiter_pkg;

  localparam int IMEM_ADDR_W = 8;
  localparam int STARVE_MAX_DEFAULT = 4;

  typedef enum logic {
    ARB_BOOT = 1'b0,
    ARB_RUN  = 1'b1
  } arb_state_e;

  // Bits needed to hold 0..max inclusive.
  function automatic int starve_cnt_width(input int max);
    return (max < 1) ? 1 : $clog2(max + 1);
  endfunction

endpackage

// File: rtl/imem_port_arbiter_if.sv
// Fetch, loader and imem-side signals of the arbiter, bundled as one bus.
// The slave modport is the arbiter's view; the master modport is the environment's view.
interface imem_port_arbiter_if
  import imem_port_arbiter_pkg::*;
#(
  parameter int ADDR_W = IMEM_ADDR_W
);
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_kill;
  logic              if_gnt;
  logic              if_stall;
  logic              if_rvalid;

  logic              ld_valid;
  logic [ADDR_W-1:0] ld_addr;
  logic [31:0]       ld_data;
  logic              ld_ready;
  logic              ld_done;

  logic [ADDR_W-1:0] mem_addr;
  logic              mem_read;
  logic              mem_write;
  logic [31:0]       mem_wdata;
  logic              booting;

  modport slave (
    input  if_req, if_addr, if_kill, ld_valid, ld_addr, ld_data, ld_done,
    output if_gnt, if_stall, if_rvalid, ld_ready,
           mem_addr, mem_read, mem_write, mem_wdata, booting
  );

  modport master (
    output if_req, if_addr, if_kill, ld_valid, ld_addr, ld_data, ld_done,
    input  if_gnt, if_stall, if_rvalid, ld_ready,
           mem_addr, mem_read, mem_write, mem_wdata, booting
  );
endinterface

// File: rtl/imem_port_arbiter_starve_counter.sv
// Saturating count of consecutive cycles the loader has been denied the port.
// Clear wins over increment; the count holds at MAX and never wraps.
module arb_starve_counter
  import imem_port_arbiter_pkg::*;
#(
  parameter int MAX = STARVE_MAX_DEFAULT,
  parameter int W   = starve_cnt_width(MAX)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] cnt,
  output logic         sat
);
  logic [W-1:0] cnt_reg;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt_reg <= '0;
    end else if (inc && !sat) begin
      cnt_reg <= cnt_reg + 1'b1;
    end
  end

  assign cnt = cnt_reg;
  assign sat = (cnt_reg == W'(MAX));
endmodule

// File: rtl/imem_port_arbiter.sv
// Shares the single-port imem between fetch reads and loader writes.
// BOOT admits only the loader; RUN favours fetch but forces a loader grant after STARVE_MAX denials.
module imem_port_arbiter
  import imem_port_arbiter_pkg::*;
#(
  parameter int ADDR_W     = IMEM_ADDR_W,
  parameter int STARVE_MAX = STARVE_MAX_DEFAULT
) (
  input  logic                 clk,
  input  logic                 rst,
  imem_port_arbiter_if.slave   bus
);
  localparam int CNT_W = starve_cnt_width(STARVE_MAX);

  arb_state_e        state_reg;
  logic              rvalid_reg;
  logic              gnt_fetch;
  logic              gnt_load;
  logic [ADDR_W-1:0] mem_addr_next;
  logic [CNT_W-1:0]  starve_cnt;
  logic              starve_sat;

  // No grant is issued while rst is high, so a write in the reset cycle is dropped.
  always_comb begin
    gnt_fetch = 1'b0;
    gnt_load  = 1'b0;
    if (!rst) begin
      case (state_reg)
        ARB_BOOT: gnt_load = bus.ld_valid;
        ARB_RUN: begin
          if (bus.ld_valid && starve_sat) begin
            gnt_load = 1'b1;
          end else if (bus.if_req) begin
            gnt_fetch = 1'b1;
          end else if (bus.ld_valid) begin
            gnt_load = 1'b1;
          end
        end
        default: ;
      endcase
    end
    mem_addr_next = gnt_load ? bus.ld_addr : bus.if_addr;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg  <= ARB_BOOT;
      rvalid_reg <= 1'b0;
    end else begin
      rvalid_reg <= gnt_fetch && !bus.if_kill;
      if (state_reg == ARB_BOOT && bus.ld_done) begin
        state_reg <= ARB_RUN;
      end
    end
  end

  arb_starve_counter #(
    .MAX (STARVE_MAX),
    .W   (CNT_W)
  ) u_starve (
    .clk (clk),
    .rst (rst),
    .clr (gnt_load || !bus.ld_valid),
    .inc (bus.ld_valid && !gnt_load),
    .cnt (starve_cnt),
    .sat (starve_sat)
  );

  assign bus.if_gnt    = gnt_fetch;
  assign bus.if_stall  = bus.if_req && !gnt_fetch;
  assign bus.if_rvalid = rvalid_reg;
  assign bus.ld_ready  = gnt_load;
  assign bus.mem_addr  = mem_addr_next;
  assign bus.mem_read  = gnt_fetch;
  assign bus.mem_write = gnt_load;
  assign bus.mem_wdata = bus.ld_data;
  assign bus.booting   = (state_reg == ARB_BOOT);
endmodule
